// File: rtl/alu_core_if.sv
// +----------------------------------------------------------------------------+
// | alu_core_if : operand/command/result bundle between ALU driver and core     |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface alu_core_if #(
  parameter int WIDTH = 8
);
  logic               ce;
  logic               mode;
  logic               cin;
  logic [3:0]         cmd;
  logic [1:0]         inp_valid;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] res;
  logic               err;
  logic               oflow;
  logic               cout;
  logic               g;
  logic               l;
  logic               e;

  modport master (
    output ce, mode, cin, cmd, inp_valid, opa, opb,
    input  res, err, oflow, cout, g, l, e
  );

  modport slave (
    input  ce, mode, cin, cmd, inp_valid, opa, opb,
    output res, err, oflow, cout, g, l, e
  );
endinterface

`default_nettype wire

// File: rtl/alu_core.sv
// +----------------------------------------------------------------------------+
// | alu_core : registered ALU with missing-operand wait and 2-cycle multiply    |
// | Option   : ALU_SIGNED_EN adds signed ADD/SUB on arithmetic cmd 11/12        |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_core #(
  parameter int WIDTH       = 8,
  parameter int WAIT_CYCLES = 16
) (
  input wire        clk,
  input wire        rst,
  alu_core_if.slave bus
);

  localparam int                 C_CNT_W   = $clog2(WAIT_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(WAIT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);
  localparam logic [WIDTH:0]     C_ONE     = (WIDTH+1)'(1);
  localparam logic [1:0]         C_CLS_AB  = 2'd0;
  localparam logic [1:0]         C_CLS_A   = 2'd1;
  localparam logic [1:0]         C_CLS_B   = 2'd2;
  localparam logic [1:0]         C_CLS_ILL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MUL  = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  function automatic logic [1:0] f_class(input logic m, input logic [3:0] c);
    logic [1:0] cls;
    cls = C_CLS_ILL;
    if (m) begin
      case (c)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10: cls = C_CLS_AB;
        4'd4, 4'd5:                                cls = C_CLS_A;
        4'd6, 4'd7:                                cls = C_CLS_B;
`ifdef ALU_SIGNED_EN
        4'd11, 4'd12:                              cls = C_CLS_AB;
`endif
        default:                                   cls = C_CLS_ILL;
      endcase
    end else begin
      case (c)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd12, 4'd13: cls = C_CLS_AB;
        4'd6, 4'd8, 4'd9:                                 cls = C_CLS_A;
        4'd7, 4'd10, 4'd11:                               cls = C_CLS_B;
        default:                                          cls = C_CLS_ILL;
      endcase
    end
    return cls;
  endfunction

  function automatic logic f_ready(input logic [1:0] cls, input logic [1:0] vld);
    logic rdy;
    case (cls)
      C_CLS_AB: rdy = (vld == 2'b11);
      C_CLS_A:  rdy = vld[0];
      C_CLS_B:  rdy = vld[1];
      default:  rdy = 1'b1;
    endcase
    return rdy;
  endfunction

  state_t               r_state;
  state_t               w_state_nx;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [3:0]           r_cmd;
  logic                 r_mode;
  logic                 r_cin;
  logic [1:0]           r_vld;
  logic [2*WIDTH-1:0]   r_prod;

  logic [2*WIDTH-1:0]   r_res;
  logic                 r_err;
  logic                 r_oflow;
  logic                 r_cout;
  logic                 r_g;
  logic                 r_l;
  logic                 r_e;

  logic                 w_take;
  logic                 w_fill;
  logic                 w_wr;
  logic                 w_tmo;
  logic [1:0]           w_in_cls;
  logic                 w_in_mul;
  logic                 w_lat_mul;
  logic [1:0]           w_lat_cls;

  logic [WIDTH:0]       w_a1;
  logic [WIDTH:0]       w_b1;
  logic [WIDTH:0]       w_c1;
  logic [2*WIDTH-1:0]   w_rol;
  logic [2*WIDTH-1:0]   w_ror;
  logic [2*WIDTH-1:0]   w_prod;

  logic [WIDTH:0]       w_t;
  logic [WIDTH-1:0]     w_lg;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_err;
  logic                 w_oflow;
  logic                 w_cout;
  logic                 w_g;
  logic                 w_l;
  logic                 w_e;

  assign w_in_cls  = f_class(bus.mode, bus.cmd);
  assign w_in_mul  = bus.mode && ((bus.cmd == 4'd9) || (bus.cmd == 4'd10));
  assign w_lat_cls = f_class(r_mode, r_cmd);
  assign w_lat_mul = r_mode && ((r_cmd == 4'd9) || (r_cmd == 4'd10));

  assign w_a1  = {1'b0, r_a};
  assign w_b1  = {1'b0, r_b};
  assign w_c1  = {{WIDTH{1'b0}}, r_cin};
  assign w_rol = {r_a, r_a} << r_b[2:0];
  assign w_ror = {r_a, r_a} >> r_b[2:0];
  assign w_prod = (r_cmd == 4'd9) ?
                  ((2*WIDTH)'(w_a1 + C_ONE) * (2*WIDTH)'(w_b1 + C_ONE)) :
                  ((2*WIDTH)'({r_a[WIDTH-2:0], 1'b0}) * (2*WIDTH)'(r_b));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (bus.ce) begin
      r_state <= w_state_nx;
    end
  end

  // EXEC also accepts a new command so back-to-back ops need no gap; MUL does not.
  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    w_fill     = 1'b0;
    w_wr       = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE, S_EXEC: begin
        w_wr = (r_state == S_EXEC);
        if (bus.inp_valid != 2'b00) begin
          w_take = 1'b1;
          if ((w_in_cls == C_CLS_AB) && (bus.inp_valid != 2'b11)) begin
            w_state_nx = S_WAIT;
          end else if (w_in_mul) begin
            w_state_nx = S_MUL;
          end else begin
            w_state_nx = S_EXEC;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_vld[0] ? bus.inp_valid[1] : bus.inp_valid[0]) begin
          w_fill     = 1'b1;
          w_state_nx = w_lat_mul ? S_MUL : S_EXEC;
        end else if (r_cnt == C_CNT_MAX) begin
          w_tmo      = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      S_MUL:   w_state_nx = S_EXEC;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_t     = '0;
    w_lg    = '0;
    w_res   = '0;
    w_err   = 1'b0;
    w_oflow = 1'b0;
    w_cout  = 1'b0;
    w_g     = 1'b0;
    w_l     = 1'b0;
    w_e     = 1'b0;
    if ((w_lat_cls == C_CLS_ILL) || !f_ready(w_lat_cls, r_vld)) begin
      w_err = 1'b1;
    end else if (r_mode) begin
      case (r_cmd)
        4'd0: begin
          w_t    = w_a1 + w_b1;
          w_cout = w_t[WIDTH];
        end
        4'd1: begin
          w_t     = w_a1 - w_b1;
          w_oflow = (w_a1 < w_b1);
        end
        4'd2: begin
          w_t    = w_a1 + w_b1 + w_c1;
          w_cout = w_t[WIDTH];
        end
        4'd3: begin
          w_t     = w_a1 - w_b1 - w_c1;
          w_oflow = (w_a1 < (w_b1 + w_c1));
        end
        4'd4: w_t = w_a1 + C_ONE;
        4'd5: w_t = w_a1 - C_ONE;
        4'd6: w_t = w_b1 + C_ONE;
        4'd7: w_t = w_b1 - C_ONE;
        4'd8: begin
          w_g = (r_a > r_b);
          w_l = (r_a < r_b);
          w_e = (r_a == r_b);
        end
`ifdef ALU_SIGNED_EN
        // Sign-extended to WIDTH+1 bits the sum is exact; overflow shows as bit W != bit W-1.
        4'd11, 4'd12: begin
          w_t     = (r_cmd == 4'd11) ? ({r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b}) :
                                       ({r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b});
          w_oflow = (w_t[WIDTH] != w_t[WIDTH-1]);
          w_g     = ($signed(r_a) >  $signed(r_b));
          w_l     = ($signed(r_a) <  $signed(r_b));
          w_e     = (r_a == r_b);
        end
`endif
        default: ;
      endcase
      if ((r_cmd == 4'd9) || (r_cmd == 4'd10)) begin
        w_res = r_prod;
`ifdef ALU_SIGNED_EN
      end else if ((r_cmd == 4'd11) || (r_cmd == 4'd12)) begin
        w_res = {{(WIDTH-1){w_t[WIDTH]}}, w_t};
`endif
      end else begin
        w_res = (2*WIDTH)'(w_t);
      end
    end else begin
      case (r_cmd)
        4'd0:  w_lg = r_a & r_b;
        4'd1:  w_lg = ~(r_a & r_b);
        4'd2:  w_lg = r_a | r_b;
        4'd3:  w_lg = ~(r_a | r_b);
        4'd4:  w_lg = r_a ^ r_b;
        4'd5:  w_lg = ~(r_a ^ r_b);
        4'd6:  w_lg = ~r_a;
        4'd7:  w_lg = ~r_b;
        4'd8:  w_lg = r_a >> 1;
        4'd9:  w_lg = r_a << 1;
        4'd10: w_lg = r_b >> 1;
        4'd11: w_lg = r_b << 1;
        4'd12: begin
          w_lg  = w_rol[2*WIDTH-1:WIDTH];
          w_err = |r_b[WIDTH-1:4];
        end
        4'd13: begin
          w_lg  = w_ror[WIDTH-1:0];
          w_err = |r_b[WIDTH-1:4];
        end
        default: ;
      endcase
      w_res = (2*WIDTH)'(w_lg);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cmd   <= '0;
      r_mode  <= 1'b0;
      r_cin   <= 1'b0;
      r_vld   <= 2'b00;
      r_prod  <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_oflow <= 1'b0;
      r_cout  <= 1'b0;
      r_g     <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
    end else if (bus.ce) begin
      if (w_take) begin
        r_a    <= bus.opa;
        r_b    <= bus.opb;
        r_cmd  <= bus.cmd;
        r_mode <= bus.mode;
        r_cin  <= bus.cin;
        r_vld  <= bus.inp_valid;
        r_cnt  <= C_CNT_ONE;
      end else if (r_state == S_WAIT) begin
        if (w_fill) begin
          if (r_vld[0]) begin
            r_b <= bus.opb;
          end else begin
            r_a <= bus.opa;
          end
          r_vld <= 2'b11;
        end else begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end
      if (r_state == S_MUL) begin
        r_prod <= w_prod;
      end
      if (w_wr) begin
        r_res   <= w_res;
        r_err   <= w_err;
        r_oflow <= w_oflow;
        r_cout  <= w_cout;
        r_g     <= w_g;
        r_l     <= w_l;
        r_e     <= w_e;
      end else if (w_tmo) begin
        r_res   <= '0;
        r_err   <= 1'b1;
        r_oflow <= 1'b0;
        r_cout  <= 1'b0;
        r_g     <= 1'b0;
        r_l     <= 1'b0;
        r_e     <= 1'b0;
      end
    end
  end

  assign bus.res   = r_res;
  assign bus.err   = r_err;
  assign bus.oflow = r_oflow;
  assign bus.cout  = r_cout;
  assign bus.g     = r_g;
  assign bus.l     = r_l;
  assign bus.e     = r_e;

endmodule

`default_nettype wire

// File: tb/tb_alu_core.sv
// +----------------------------------------------------------------------------+
// | tb_alu_core : vector table, corner sequences and random ops vs. a model     |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_core;
  localparam int WIDTH       = 8;
  localparam int WAIT_CYCLES = 16;

  logic clk = 1'b0;
  logic rst;

  alu_core_if #(.WIDTH(WIDTH)) bus ();

  alu_core #(
    .WIDTH      (WIDTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        err;
    logic        oflow;
    logic        cout;
    logic        g;
    logic        l;
    logic        e;
  } out_t;

  typedef struct {
    string    nm;
    bit       m;
    bit [3:0] c;
    bit [1:0] v;
    bit [7:0] a;
    bit [7:0] b;
    bit       ci;
    out_t     x;
  } vec_t;

  int   n_err = 0;
  int   n_chk = 0;
  vec_t tbl[$];

  function automatic out_t ex(input logic [15:0] r, input logic er, input logic of,
                              input logic co, input logic gg, input logic ll, input logic ee);
    return {r, er, of, co, gg, ll, ee};
  endfunction

  // Operand class: 0 two-operand, 1 A only, 2 B only, 3 illegal
  function automatic int cls_of(input bit m, input bit [3:0] c);
    if (m) begin
      if (c <= 4'd3 || c == 4'd8 || c == 4'd9 || c == 4'd10) return 0;
      if (c == 4'd4 || c == 4'd5) return 1;
      if (c == 4'd6 || c == 4'd7) return 2;
      return 3;
    end
    if (c <= 4'd5 || c == 4'd12 || c == 4'd13) return 0;
    if (c == 4'd6 || c == 4'd8 || c == 4'd9) return 1;
    if (c == 4'd7 || c == 4'd10 || c == 4'd11) return 2;
    return 3;
  endfunction

  function automatic bit is_mul(input bit m, input bit [3:0] c);
    return m && (c == 4'd9 || c == 4'd10);
  endfunction

  function automatic out_t model(input bit m, input bit [3:0] c, input bit [1:0] v,
                                 input bit [7:0] a8, input bit [7:0] b8, input bit ci);
    out_t     o;
    int       a, b, k, r, cc;
    bit [7:0] x;
    o  = '0;
    a  = int'(a8);
    b  = int'(b8);
    cc = ci ? 1 : 0;
    k  = cls_of(m, c);
    r  = 0;
    x  = 8'h00;
    if (k == 3 || (k == 0 && v != 2'b11) || (k == 1 && !v[0]) || (k == 2 && !v[1])) begin
      o.err = 1'b1;
      return o;
    end
    if (m) begin
      case (c)
        4'd0: begin r = a + b;                  o.cout  = (r > 255);    end
        4'd1: begin r = (a - b + 512) % 512;    o.oflow = (a < b);      end
        4'd2: begin r = a + b + cc;             o.cout  = (r > 255);    end
        4'd3: begin r = (a - b - cc + 512) % 512; o.oflow = (a < b + cc); end
        4'd4: r = a + 1;
        4'd5: r = (a + 511) % 512;
        4'd6: r = b + 1;
        4'd7: r = (b + 511) % 512;
        4'd8: begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
        4'd9: r = ((a + 1) * (b + 1)) % 65536;
        default: r = ((a * 2) % 256) * b;
      endcase
    end else begin
      case (c)
        4'd0:  x = a8 & b8;
        4'd1:  x = ~(a8 & b8);
        4'd2:  x = a8 | b8;
        4'd3:  x = ~(a8 | b8);
        4'd4:  x = a8 ^ b8;
        4'd5:  x = ~(a8 ^ b8);
        4'd6:  x = ~a8;
        4'd7:  x = ~b8;
        4'd8:  x = 8'((a / 2) % 256);
        4'd9:  x = 8'((a * 2) % 256);
        4'd10: x = 8'((b / 2) % 256);
        4'd11: x = 8'((b * 2) % 256);
        4'd12: begin
          x = a8;
          for (int i = 0; i < b % 8; i++) x = {x[6:0], x[7]};
          o.err = (b >= 16);
        end
        default: begin
          x = a8;
          for (int i = 0; i < b % 8; i++) x = {x[0], x[7:1]};
          o.err = (b >= 16);
        end
      endcase
      r = int'(x);
    end
    o.res = 16'(r);
    return o;
  endfunction

  task automatic check(input string nm, input out_t x);
    out_t act;
    act = {bus.res, bus.err, bus.oflow, bus.cout, bus.g, bus.l, bus.e};
    n_chk++;
    if (act !== x) begin
      n_err++;
      $display("FAIL %s: got res=%h err/oflow/cout/g/l/e=%b required res=%h err/oflow/cout/g/l/e=%b",
               nm, act.res, act[5:0], x.res, x[5:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input bit [3:0] c, input bit [1:0] v,
                       input bit [7:0] a, input bit [7:0] b, input bit ci);
    bus.mode      = m;
    bus.cmd       = c;
    bus.inp_valid = v;
    bus.opa       = a;
    bus.opb       = b;
    bus.cin       = ci;
  endtask

  task automatic run_op(input bit m, input bit [3:0] c, input bit [1:0] v,
                        input bit [7:0] a, input bit [7:0] b, input bit ci);
    drive(m, c, v, a, b, ci);
    tick();
    bus.inp_valid = 2'b00;
    tick();
    if (is_mul(m, c)) tick();
  endtask

  task automatic addv(input string nm, input bit m, input bit [3:0] c, input bit [1:0] v,
                      input bit [7:0] a, input bit [7:0] b, input bit ci, input out_t x);
    vec_t t;
    t.nm = nm; t.m = m; t.c = c; t.v = v; t.a = a; t.b = b; t.ci = ci; t.x = x;
    tbl.push_back(t);
  endtask

  initial begin
    bit       rm, rci;
    bit [3:0] rc;
    bit [1:0] rv;
    bit [7:0] ra, rb;

    addv("add_ff_01",   1'b1, 4'd0,  2'b11, 8'hFF, 8'h01, 1'b0, ex(16'h0100, 0, 0, 1, 0, 0, 0));
    addv("cmp_lt",      1'b1, 4'd8,  2'b11, 8'd5,  8'd9,  1'b0, ex(16'h0000, 0, 0, 0, 0, 1, 0));
    addv("cmp_eq",      1'b1, 4'd8,  2'b11, 8'h3C, 8'h3C, 1'b0, ex(16'h0000, 0, 0, 0, 0, 0, 1));
    addv("cmp_gt",      1'b1, 4'd8,  2'b11, 8'h80, 8'h7F, 1'b0, ex(16'h0000, 0, 0, 0, 1, 0, 0));
    addv("sub_borrow",  1'b1, 4'd1,  2'b11, 8'd3,  8'd5,  1'b0, ex(16'h01FE, 0, 1, 0, 0, 0, 0));
    addv("subcin_5_5",  1'b1, 4'd3,  2'b11, 8'd5,  8'd5,  1'b1, ex(16'h01FF, 0, 1, 0, 0, 0, 0));
    addv("addcin_max",  1'b1, 4'd2,  2'b11, 8'hFF, 8'hFF, 1'b1, ex(16'h01FF, 0, 0, 1, 0, 0, 0));
    addv("inc_a_ff",    1'b1, 4'd4,  2'b01, 8'hFF, 8'h00, 1'b0, ex(16'h0100, 0, 0, 0, 0, 0, 0));
    addv("dec_b",       1'b1, 4'd7,  2'b10, 8'h00, 8'h10, 1'b0, ex(16'h000F, 0, 0, 0, 0, 0, 0));
    addv("inc_a_noopa", 1'b1, 4'd4,  2'b10, 8'h12, 8'h34, 1'b0, ex(16'h0000, 1, 0, 0, 0, 0, 0));
    addv("mul_shl",     1'b1, 4'd10, 2'b11, 8'h81, 8'h03, 1'b0, ex(16'h0006, 0, 0, 0, 0, 0, 0));
    addv("mul_inc_0f",  1'b1, 4'd9,  2'b11, 8'h0F, 8'h0F, 1'b0, ex(16'h0100, 0, 0, 0, 0, 0, 0));
    addv("arith_ill11", 1'b1, 4'd11, 2'b11, 8'h01, 8'h02, 1'b0, ex(16'h0000, 1, 0, 0, 0, 0, 0));
    addv("arith_ill13", 1'b1, 4'd13, 2'b01, 8'h01, 8'h02, 1'b0, ex(16'h0000, 1, 0, 0, 0, 0, 0));
    addv("nand",        1'b0, 4'd1,  2'b11, 8'hF0, 8'h3C, 1'b0, ex(16'h00CF, 0, 0, 0, 0, 0, 0));
    addv("nor",         1'b0, 4'd3,  2'b11, 8'hF0, 8'h0F, 1'b0, ex(16'h0000, 0, 0, 0, 0, 0, 0));
    addv("xnor",        1'b0, 4'd5,  2'b11, 8'hAA, 8'h0F, 1'b0, ex(16'h005A, 0, 0, 0, 0, 0, 0));
    addv("rol_bad_amt", 1'b0, 4'd12, 2'b11, 8'h81, 8'h11, 1'b0, ex(16'h0003, 1, 0, 0, 0, 0, 0));
    addv("ror_1",       1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0, ex(16'h00C0, 0, 0, 0, 0, 0, 0));
    addv("shl1_b",      1'b0, 4'd11, 2'b10, 8'h00, 8'h81, 1'b0, ex(16'h0002, 0, 0, 0, 0, 0, 0));
    addv("shr1_a",      1'b0, 4'd8,  2'b01, 8'h81, 8'h00, 1'b0, ex(16'h0040, 0, 0, 0, 0, 0, 0));
    addv("logic_ill15", 1'b0, 4'd15, 2'b11, 8'h81, 8'h00, 1'b0, ex(16'h0000, 1, 0, 0, 0, 0, 0));

    bus.ce = 1'b1;
    drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    check("reset_state", ex(16'h0000, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    tick();

    foreach (tbl[i]) begin
      run_op(tbl[i].m, tbl[i].c, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].ci);
      check(tbl[i].nm, tbl[i].x);
    end

    // Multiply: an offer in the cycle after sampling must be dropped.
    drive(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
    tick();
    drive(1'b0, 4'd2, 2'b11, 8'h11, 8'h22, 1'b0);
    tick();
    bus.inp_valid = 2'b00;
    tick();
    check("mul_inc_3_4", ex(16'd20, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    check("mul_gap_ignored", ex(16'd20, 0, 0, 0, 0, 0, 0));

    // Late operand B after 5 idle cycles; cmd/mode during the fill must be ignored.
    drive(1'b0, 4'd4, 2'b01, 8'hAA, 8'h00, 1'b0);
    tick();
    bus.inp_valid = 2'b00;
    repeat (5) tick();
    drive(1'b1, 4'd0, 2'b10, 8'h55, 8'h0F, 1'b0);
    tick();
    bus.inp_valid = 2'b00;
    tick();
    check("wait_fill_xor", ex(16'h00A5, 0, 0, 0, 0, 0, 0));

    // Missing operand never arrives: error exactly WAIT_CYCLES edges after entry.
    drive(1'b0, 4'd4, 2'b01, 8'hAA, 8'h00, 1'b0);
    tick();
    bus.inp_valid = 2'b00;
    repeat (WAIT_CYCLES - 1) tick();
    check("timeout_not_yet", ex(16'h00A5, 0, 0, 0, 0, 0, 0));
    tick();
    check("timeout_err", ex(16'h0000, 1, 0, 0, 0, 0, 0));
    run_op(1'b1, 4'd0, 2'b11, 8'd1, 8'd2, 1'b0);
    check("after_timeout", ex(16'h0003, 0, 0, 0, 0, 0, 0));

    // Clock enable low: nothing sampled, outputs hold.
    bus.ce = 1'b0;
    drive(1'b1, 4'd0, 2'b11, 8'd10, 8'd20, 1'b0);
    tick();
    tick();
    bus.inp_valid = 2'b00;
    check("ce_low_hold", ex(16'h0003, 0, 0, 0, 0, 0, 0));
    bus.ce = 1'b1;
    tick();
    tick();
    check("ce_high_no_stale", ex(16'h0003, 0, 0, 0, 0, 0, 0));

    // Reset in WAIT discards the pending half-command.
    run_op(1'b0, 4'd12, 2'b11, 8'h81, 8'h11, 1'b0);
    check("rol_before_reset", ex(16'h0003, 1, 0, 0, 0, 0, 0));
    drive(1'b0, 4'd4, 2'b01, 8'hAA, 8'h00, 1'b0);
    tick();
    bus.inp_valid = 2'b00;
    tick();
    tick();
    check("wait_holds_outputs", ex(16'h0003, 1, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #2;
    check("async_reset_in_wait", ex(16'h0000, 0, 0, 0, 0, 0, 0));
    #2 rst = 1'b1;
    tick();
    drive(1'b0, 4'd4, 2'b10, 8'h00, 8'h0F, 1'b0);
    tick();
    bus.inp_valid = 2'b00;
    tick();
    tick();
    check("no_combine_after_reset", ex(16'h0000, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();

    for (int i = 0; i < 300; i++) begin
      rm  = 1'($urandom_range(0, 1));
      rc  = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom_range(0, 1));
      rv  = 2'($urandom_range(1, 3));
      if (cls_of(rm, rc) == 0) rv = 2'b11;
      run_op(rm, rc, rv, ra, rb, rci);
      check($sformatf("rand%0d_m%0d_c%0d", i, rm, rc), model(rm, rc, rv, ra, rb, rci));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
